// File: rtl/codec_init.sv
// WM8731 init sequencer: PWRUP wait, then 11 register writes (or one volume write) via an external I2C master.
// Latency: one wr_i2c strobe per write, >= GAP_CYCLES apart; stalls in ISSUE/WAIT_IDLE while i2c_idle=0, errors out after TIMEOUT_CYCLES.
module codec_init #(
  parameter logic [7:0] DEV_ADDR       = 8'h34,
  parameter int         PWRUP_CYCLES   = 1_000_000,
  parameter int         GAP_CYCLES     = 16,
  parameter int         TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        vol_wr,
  input  logic [6:0]  vol_val,
  input  logic        i2c_idle,
  output logic        wr_i2c,
  output logic [23:0] i2c_packet,
  output logic        init_done,
  output logic        busy,
  output logic        err
);

  localparam int CNT_MAX = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] LAST_IDX = 4'd10;

  typedef enum logic [2:0] {PWRUP, ISSUE, GAP, WAIT_IDLE, DONE, ERROR} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0]    idx, idx_n;
  logic          vol_mode, vol_mode_n;
  logic [6:0]    vol_reg, vol_reg_n;
  logic          wr_n;
  logic [23:0]   pkt_n;
  logic          err_n;

  // {reg_addr[6:0], data[8:0]} for each init step
  function automatic logic [15:0] init_entry(input logic [3:0] i);
    case (i)
      4'd0:    init_entry = {7'd15, 9'h000};
      4'd1:    init_entry = {7'd0,  9'h017};
      4'd2:    init_entry = {7'd1,  9'h017};
      4'd3:    init_entry = {7'd2,  9'h079};
      4'd4:    init_entry = {7'd3,  9'h079};
      4'd5:    init_entry = {7'd4,  9'h012};
      4'd6:    init_entry = {7'd5,  9'h000};
      4'd7:    init_entry = {7'd6,  9'h000};
      4'd8:    init_entry = {7'd7,  9'h002};
      4'd9:    init_entry = {7'd8,  9'h000};
      4'd10:   init_entry = {7'd9,  9'h001};
      default: init_entry = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PWRUP;
      cnt        <= '0;
      tcnt       <= '0;
      idx        <= '0;
      vol_mode   <= 1'b0;
      vol_reg    <= '0;
      wr_i2c     <= 1'b0;
      i2c_packet <= 24'h0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      tcnt       <= tcnt_n;
      idx        <= idx_n;
      vol_mode   <= vol_mode_n;
      vol_reg    <= vol_reg_n;
      wr_i2c     <= wr_n;
      i2c_packet <= pkt_n;
      err        <= err_n;
    end
  end

  // Counters default to zero so every state change clears them.
  always_comb begin
    state_n    = state;
    cnt_n      = '0;
    tcnt_n     = '0;
    idx_n      = idx;
    vol_mode_n = vol_mode;
    vol_reg_n  = vol_reg;
    wr_n       = 1'b0;
    pkt_n      = i2c_packet;
    err_n      = err;
    case (state)
      PWRUP: begin
        if (cnt == CW'(PWRUP_CYCLES - 1)) begin
          state_n = ISSUE;
          idx_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ISSUE: begin
        if (i2c_idle) begin
          wr_n    = 1'b1;
          pkt_n   = {DEV_ADDR, vol_mode ? {7'd2, 1'b1, 1'b0, vol_reg} : init_entry(idx)};
          state_n = GAP;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = ERROR;
          err_n   = 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) state_n = WAIT_IDLE;
        else                            cnt_n   = cnt + 1'b1;
      end
      WAIT_IDLE: begin
        if (i2c_idle) begin
          if (vol_mode || idx == LAST_IDX) begin
            state_n    = DONE;
            vol_mode_n = 1'b0;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = ISSUE;
          end
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = ERROR;
          err_n   = 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      DONE: begin
        // start has priority; a simultaneous volume request is dropped
        if (start) begin
          state_n    = PWRUP;
          idx_n      = '0;
          vol_mode_n = 1'b0;
        end else if (vol_wr) begin
          vol_reg_n  = vol_val;
          vol_mode_n = 1'b1;
          state_n    = ISSUE;
        end
      end
      ERROR: begin
        if (start) begin
          state_n    = PWRUP;
          err_n      = 1'b0;
          idx_n      = '0;
          vol_mode_n = 1'b0;
        end
      end
      default: state_n = PWRUP;
    endcase
  end

  assign init_done = (state == DONE);
  assign busy      = (state != DONE) && (state != ERROR);

endmodule

// File: tb/tb_codec_init.sv
// Bench for codec_init: I2C master model, scoreboard of expected packets checked by a negedge monitor.
module tb_codec_init;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        vol_wr;
  logic [6:0]  vol_val;
  logic        i2c_idle;
  logic        wr_i2c;
  logic [23:0] i2c_packet;
  logic        init_done;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];
  logic [23:0] init_pkts [11] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479,
                                  24'h340679, 24'h340812, 24'h340A00, 24'h340C00,
                                  24'h340E02, 24'h341000, 24'h341201};

  codec_init #(
    .DEV_ADDR(8'h34), .PWRUP_CYCLES(8), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .vol_wr(vol_wr), .vol_val(vol_val),
    .i2c_idle(i2c_idle), .wr_i2c(wr_i2c), .i2c_packet(i2c_packet),
    .init_done(init_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // I2C master model: idle drops with each write and returns 20 cycles later,
  // unless hang_at names this write, in which case it stays low until hang_at is cleared.
  int idle_cnt = 0;
  int model_wr = 0;
  int hang_at  = 0;
  logic stuck  = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      i2c_idle = 1'b1;
      idle_cnt = 0;
      stuck    = 1'b0;
    end else begin
      if (hang_at == 0) stuck = 1'b0;
      if (wr_i2c) begin
        model_wr++;
        i2c_idle = 1'b0;
        idle_cnt = 20;
        if (hang_at != 0 && model_wr == hang_at) stuck = 1'b1;
      end else if (idle_cnt > 1) begin
        idle_cnt--;
      end else begin
        idle_cnt = 0;
        i2c_idle = !stuck;
      end
    end
  end

  // Scoreboard monitor
  int   wr_count = 0;
  logic prev_wr  = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (wr_i2c) begin
        wr_count++;
        check("wr_spacing", {31'b0, prev_wr & wr_i2c}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wr: got packet %0h expected no write", i2c_packet);
        end else begin
          check("packet", {8'b0, i2c_packet}, {8'b0, exp_q.pop_front()});
        end
      end
      prev_wr = wr_i2c;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic push_init();
    for (int i = 0; i < 11; i++) exp_q.push_back(init_pkts[i]);
  endtask

  task automatic push_first(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(init_pkts[i]);
  endtask

  task automatic wait_wr(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!wr_i2c && n < 500);
    check(name, {31'b0, wr_i2c}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!init_done && n < 2000);
    check(name, {31'b0, init_done}, 32'd1);
  endtask

  // Called at a negedge right after reset release or a start pulse edge.
  task automatic measure_first(input string name);
    int c = 0;
    do begin @(negedge clk); c++; end while (!wr_i2c && c < 100);
    check(name, c, 32'd9);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"},   {31'b0, wr_i2c},    32'd0);
    check({tag, "_pkt"},  {8'b0, i2c_packet}, 32'd0);
    check({tag, "_done"}, {31'b0, init_done}, 32'd0);
    check({tag, "_err"},  {31'b0, err},       32'd0);
    check({tag, "_busy"}, {31'b0, busy},      32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int base;
    int lat;
    reset   = 1'b0;
    start   = 1'b0;
    vol_wr  = 1'b0;
    vol_val = 7'h00;
    #1;
    check_reset_outputs("rst");

    // Power-up init sequence
    repeat (2) @(negedge clk);
    push_init();
    reset = 1'b1;
    measure_first("pwrup_latency");
    wait_done("init_done");
    check("busy_in_done", {31'b0, busy}, 32'd0);
    check("err_in_done",  {31'b0, err},  32'd0);
    check("queue_after_init", exp_q.size(), 32'd0);

    // Volume write
    exp_q.push_back(24'h340560);
    vol_val = 7'h60;
    vol_wr  = 1'b1;
    @(negedge clk);
    vol_wr = 1'b0;
    check("vol_busy",      {31'b0, busy},      32'd1);
    check("vol_done_low",  {31'b0, init_done}, 32'd0);
    wait_wr("vol_wr_seen");
    check("vol_done_during", {31'b0, init_done}, 32'd0);
    wait_done("vol_done_after");
    check("queue_after_vol", exp_q.size(), 32'd0);

    // start + vol_wr together, then both while busy
    push_init();
    start   = 1'b1;
    vol_wr  = 1'b1;
    vol_val = 7'h11;
    @(negedge clk);
    start  = 1'b0;
    vol_wr = 1'b0;
    base = wr_count;
    wait_wr("reinit_wr1");
    wait_wr("reinit_wr2");
    start  = 1'b1;
    vol_wr = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    vol_wr = 1'b0;
    wait_done("reinit_done");
    check("reinit_wr_count", wr_count - base, 32'd11);
    check("queue_after_reinit", exp_q.size(), 32'd0);

    // Timeout: master hangs after 3rd packet
    hang_at = model_wr + 3;
    push_first(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_wr("hang_wr1");
    wait_wr("hang_wr2");
    wait_wr("hang_wr3");
    lat = 0;
    do begin @(negedge clk); lat++; end while (!err && lat < 200);
    check("err_latency", lat, 32'd68);
    check("err_set",       {31'b0, err},       32'd1);
    check("err_busy",      {31'b0, busy},      32'd0);
    check("err_done",      {31'b0, init_done}, 32'd0);
    check("queue_at_err",  exp_q.size(),       32'd0);
    vol_wr = 1'b1;
    @(negedge clk);
    vol_wr = 1'b0;
    base = wr_count;
    repeat (12) @(negedge clk);
    check("vol_in_error_writes", wr_count - base, 32'd0);
    check("err_sticky", {31'b0, err}, 32'd1);
    hang_at = 0;
    push_init();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_cleared", {31'b0, err},  32'd0);
    check("restart_busy", {31'b0, busy}, 32'd1);
    wait_done("recover_done");
    check("queue_after_recover", exp_q.size(), 32'd0);

    // Reset in the cycle after the 5th write
    push_init();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) wait_wr("pre_reset_wr");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    push_init();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    measure_first("post_reset_latency");
    wait_done("post_reset_done");
    check("queue_after_reset", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/codec_init.md
CODEC_INIT -- requirements
Module: codec_init

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 8'h34, the WM8731 I2C write address placed in packet bits [23:16].
REQ-002 The block SHALL have parameter PWRUP_CYCLES, default 1_000_000, the wait after reset or start before the first write.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 16 (legal range >=2), the wait after each wr_i2c pulse before i2c_idle is sampled.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 2_000_000, the maximum wait for i2c_idle before error.
REQ-005 The block SHALL have port clk, input, 1 bit, the system clock.
REQ-006 The block SHALL have port reset, input, 1 bit; one clock; reset is asynchronous and active-low.
REQ-007 The block SHALL have port start, input, 1 bit, a one-cycle request to re-run the full init sequence.
REQ-008 The block SHALL have port vol_wr, input, 1 bit, a one-cycle request to write headphone volume.
REQ-009 The block SHALL have port vol_val, input, 7 bits, the headphone volume code.
REQ-010 The block SHALL have port i2c_idle, input, 1 bit, the I2C master ready flag.
REQ-011 The block SHALL have port wr_i2c, output, 1 bit, a one-cycle write strobe to the I2C master.
REQ-012 The block SHALL have port i2c_packet, output, 24 bits, the packet {DEV_ADDR, reg_addr[6:0], data[8:0]}.
REQ-013 The block SHALL have port init_done, output, 1 bit, high while the codec is configured and idle.
REQ-014 The block SHALL have port busy, output, 1 bit, high in every state except DONE and ERROR.
REQ-015 The block SHALL have port err, output, 1 bit, a sticky flag set on i2c_idle timeout.

Function
REQ-016 The block SHALL hold an 11-entry init table, in this order, written as (reg, data): (15,000) (0,017) (1,017) (2,079) (3,079) (4,012) (5,000) (6,000) (7,002) (8,000) (9,001).
REQ-017 The FSM states SHALL be PWRUP, ISSUE, GAP, WAIT_IDLE, DONE and ERROR.
REQ-018 In PWRUP, the block SHALL count PWRUP_CYCLES cycles, clear the table index to 0, then go to ISSUE.
REQ-019 In ISSUE, when i2c_idle=1, the block SHALL drive i2c_packet from the current entry, pulse wr_i2c high for exactly one cycle, and go to GAP; when i2c_idle=0 it SHALL stay in ISSUE.
REQ-020 i2c_packet SHALL be registered, SHALL be valid in the wr_i2c cycle, and SHALL hold its value until the next write.
REQ-021 In GAP, the block SHALL count GAP_CYCLES cycles, then go to WAIT_IDLE.
REQ-022 In WAIT_IDLE, when i2c_idle=1:
- if the index is below 10: increment the index and go to ISSUE;
- if the index is 10: go to DONE;
- if the write was a volume write: go to DONE.
REQ-023 The timeout counter SHALL run in ISSUE and WAIT_IDLE and clear on every state change; on reaching TIMEOUT_CYCLES the block SHALL go to ERROR and set err.
REQ-024 In DONE, init_done SHALL be 1; on vol_wr the block SHALL capture vol_val and issue one write with reg 2 and data {1'b1, 1'b0, vol_val} (LRHPBOTH=1, LZCEN=0) through ISSUE/GAP/WAIT_IDLE, with init_done=0 during that write.
REQ-025 In DONE or ERROR, start SHALL clear err and init_done and go to PWRUP.
REQ-026 start and vol_wr SHALL be ignored while busy=1.
REQ-027 When start and vol_wr are asserted in the same cycle in DONE, start SHALL win and the volume request SHALL be discarded.
REQ-028 vol_wr in ERROR SHALL be ignored.
REQ-029 The block SHALL never issue wr_i2c in two consecutive cycles.

Reset
REQ-030 Reset assertion SHALL force, asynchronously: state PWRUP, index 0, all counters 0, wr_i2c=0, i2c_packet=24'h0, init_done=0, err=0, busy=1.
REQ-031 Reset mid-write SHALL abandon the write; after release the sequence SHALL restart at entry 0 following the full PWRUP wait.

Verification (PWRUP_CYCLES=8, GAP_CYCLES=4, TIMEOUT_CYCLES=64; the I2C model holds i2c_idle=1, drops it 1 cycle after wr_i2c, and raises it 20 cycles later)
REQ-032 Release reset -> no wr_i2c for 8 cycles; then 11 single-cycle pulses with packets 24'h341E00, 24'h340017, ..., 24'h341201 in table order; then init_done=1, busy=0.
REQ-033 In DONE, vol_wr with vol_val=7'h60 -> one packet 24'h340560; init_done low during the write, high after it.
REQ-034 The model holds i2c_idle=0 after the 3rd packet -> err=1 and ERROR reached 64 cycles after entering WAIT_IDLE; then start -> err=0, sequence restarts at 24'h341E00.
REQ-035 start and vol_wr together in DONE -> full re-init and no volume packet; vol_wr while busy -> no effect.
REQ-036 Reset asserted in the cycle after the 5th wr_i2c -> outputs at reset values immediately; after release, the first packet is 24'h341E00, 8 cycles later.
